// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder sequencer around an external 4-bit ripple adder, one nibble per cycle LSB first.
// Result valid NIBBLES cycles after the accept edge; the result is held in DONE until out_ready, and no new operands are taken meanwhile.
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic [3:0]       add_p,
   output logic [3:0]       add_q,
   output logic             add_c0,
   input  logic [4:0]       add_r
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   generate
      if ((WIDTH < 4) || (WIDTH % 4 != 0)) begin : g_bad_width
         $error("WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
   logic [CNT_W-1:0] cnt;
   logic             carry_r;
   logic             sa, sb;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at [3:0].
   assign sum_nxt = WIDTH'({add_r[3:0], sum_sh} >> 4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      add_p     = 4'd0;
      add_q     = 4'd0;
      add_c0    = 1'b0;
      case (state)
         IDLE: if (in_valid) state_nxt = RUN;
         RUN: begin
            add_p  = a_sh[3:0];
            add_q  = b_sh[3:0];
            add_c0 = carry_r;
            if (cnt == LAST_CNT) state_nxt = DONE;
         end
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         cnt     <= '0;
         carry_r <= 1'b0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry_r <= cin;
                  cnt     <= '0;
                  sa      <= a[WIDTH-1];
                  sb      <= b[WIDTH-1];
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 4;
               b_sh    <= b_sh >> 4;
               sum_sh  <= sum_nxt;
               carry_r <= add_r[4];
               cnt     <= cnt + CNT_W'(1);
               // Outputs only update on the final nibble so they hold their old value through IDLE and RUN.
               if (cnt == LAST_CNT) begin
                  sum_q  <= sum_nxt;
                  cout_q <= add_r[4];
                  ovf_q  <= (sa == sb) && (add_r[3] != sa);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == RUN);
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: behavioural 4-bit adder on add_*, queued expected results checked by a monitor.
module tb_nibble_serial_adder_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  a, b;
   logic          cin;
   logic          out_valid, out_ready;
   logic [W-1:0]  sum;
   logic          cout, ovf, busy;
   logic [3:0]    add_p, add_q;
   logic          add_c0;
   logic [4:0]    add_r;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic [3:0] c0_seq;

   always #5 clk = ~clk;

   // Parent-side ripple adder
   assign add_r = {1'b0, add_p} + {1'b0, add_q} + {4'd0, add_c0};

   nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy),
      .add_p(add_p), .add_q(add_q), .add_c0(add_c0), .add_r(add_r)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: compare every completed result handshake against the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sum", 32'(sum), 32'(e.s));
            check("cout", 32'(cout), 32'(e.c));
            check("ovf", 32'(ovf), 32'(e.o));
         end
      end
   end

   // Called 1ns after a posedge; returns 1ns after the accept edge.
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic eo, input bit push);
      int n;
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      if (push) sb_q.push_back('{s: es, c: ec, o: eo});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
   endtask

   // Counts edges from the accept edge until out_valid, recording add_c0 per RUN cycle.
   task automatic wait_result();
      int n;
      n = 0;
      c0_seq = 4'd0;
      while (!out_valid && n < 20) begin
         if (n < 4) c0_seq[n] = add_c0;
         @(posedge clk);
         #1;
         n++;
         if (n == 1) check("busy_run", 32'(busy), 32'd1);
      end
      check("latency", 32'(n), 32'd4);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
      check("rst_add_if", 32'({add_p, add_q, add_c0}), 32'd0);
      #8 rst_n = 1'b1;
      @(posedge clk); #1;

      issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
      wait_result();
      @(posedge clk); #1;

      issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
      wait_result();
      check("add_c0_seq", 32'(c0_seq), 32'h0000_000E);
      @(posedge clk); #1;

      issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
      wait_result();
      @(posedge clk); #1;

      issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
      wait_result();
      @(posedge clk); #1;

      issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1);
      wait_result();
      @(posedge clk); #1;

      // Backpressure: result held while new operands wait on in_valid
      out_ready = 1'b0;
      issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1);
      wait_result();
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold", 32'({sum, cout, ovf}), 32'({16'h1000, 1'b0, 1'b0}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready_back", 32'(in_ready), 32'd1);
      sb_q.push_back('{s: 16'h3333, c: 1'b0, o: 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result();
      @(posedge clk); #1;

      // Asynchronous reset during the second RUN cycle
      issue(16'hAAAA, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_add_if", 32'({add_p, add_q, add_c0}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1);
      wait_result();
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands, 4 bits per cycle, on the team's 4-bit ripple-carry adder (ripple_carry_adder4).
- Sits directly upstream and downstream of that adder.
  - It drives the adder's p/q/c0 inputs one nibble per cycle, least significant nibble first.
  - It consumes the adder's 5-bit r result and chains r[4] back as the next carry-in.
  - It assembles the full sum.
- The adder is instantiated by the parent, not inside this block; operands and results use valid/ready handshakes.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIBBLES is derived as WIDTH/4 (localparam) and is not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low; it forces every register to its reset value immediately.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned, or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to the least significant nibble.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN state.
- add_p  output  4  to adder p.
- add_q  output  4  to adder q.
- add_c0  output  1  to adder c0.
- add_r  input  5  from adder r; combinational function of add_p/add_q/add_c0 in the same cycle.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, all internal shift, count and carry registers 0.
- add_p, add_q and add_c0 are 0 outside RUN.
- States:
  - IDLE: in_ready=1. On the edge with in_valid=1:
    - latch a into a_sh and b into b_sh;
    - set carry_r=cin and cnt=0;
    - latch a[WIDTH-1] and b[WIDTH-1] as sign bits;
    - go to RUN.
  - RUN: in_ready=0, busy=1. The adder is driven combinationally: add_p=a_sh[3:0], add_q=b_sh[3:0], add_c0=carry_r. Each edge:
    - a_sh and b_sh shift right 4;
    - sum_sh shifts right 4 with add_r[3:0] entering at bits [WIDTH-1:WIDTH-4];
    - carry_r<=add_r[4];
    - cnt<=cnt+1.
    - On the edge where cnt==NIBBLES-1 the state goes to DONE.
  - DONE: out_valid=1; sum=sum_sh and cout=carry_r, held stable.
    - ovf=(sa==sb)&&(sum[WIDTH-1]!=sa).
    - On an edge with out_ready=1 the state goes to IDLE.
- Timing:
  - Operand accept edge at T: out_valid rises after edge T+NIBBLES.
  - With out_ready held high, in_ready returns after edge T+NIBBLES+1.
  - Maximum throughput is one operation per NIBBLES+2 cycles.
- Inputs ignored outside their handshake state:
  - in_valid is ignored when in_ready=0, including in_valid asserted in DONE; no pipelining of a second operation.
  - out_ready is ignored outside DONE.
- a, b and cin may change after the accept edge without effect.
- sum, cout and ovf keep their last values in IDLE and RUN; they are only meaningful while out_valid=1.
- Carry chaining: the nibble-i carry-in is exactly the nibble-(i-1) adder r[4]. No lookahead.
- Reset asserted mid-RUN or in DONE: the operation is abandoned, the result is lost, and outputs return to reset values immediately. After rst_n deasserts, the first accept happens on the first clk edge with in_valid=1.
- WIDTH=4: a single RUN cycle.
- cnt width is clog2(NIBBLES), minimum 1 bit.

Test Plan (WIDTH=16, parent wires ripple_carry_adder4 to add_*):
- 0x1234 + 0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Check add_c0 = 0,1,1,1 across the four RUN cycles.
- 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Then 0x8000 + 0x8000 -> sum=0x0000, cout=1, ovf=1.
- 0xFFFF + 0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
- Backpressure, using 0x0F0F + 0x00F1 -> sum=0x1000, cout=0:
  - hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands applied;
  - sum/cout/ovf/out_valid must stay stable and in_ready must stay 0;
  - after out_ready=1, in_ready=1 on the next cycle and the new operands are accepted.
- Reset mid-operation:
  - assert rst_n=0 asynchronously (between edges) during the 2nd RUN cycle;
  - all outputs go to reset values immediately;
  - after release, 0x0001 + 0x0002 -> sum=0x0003 with no trace of the abandoned operation.
